// File: rtl/jacobi_pair_scheduler.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler
//
// Sequences one cyclic-by-row Jacobi run over an N x N symmetric matrix held
// row-major in a shared dual-port BRAM. For every (p,q) pair, p < q, it reads
// a_pp/a_qq, then a_pq/a_qp. It then launches the vectoring CORDIC with
// x = a_qq - a_pp and y = 2*a_pq, and waits for the rotation/writeback stage to
// report the pair complete. After SWEEPS full sweeps it pulses done_o.
//
// Optional build macro: JACOBI_SKIP_ZERO_EN
//   When defined, a pair whose a_pq is zero is not issued. The pair is advanced
//   straight away and skip_o pulses for one cycle. When undefined, every pair is
//   issued and skip_o does not exist.
//
// Ports:
//   clk            clock
//   rst            synchronous active-low reset
//   start_i        run request pulse, sampled only in idle
//   busy_o         high in every state except idle
//   done_o         one-cycle pulse at the end of a run
//   ram_en_o       BRAM enable for both ports (reads only)
//   ram_addr_a_o   port A read address
//   ram_addr_b_o   port B read address
//   ram_dout_a_i   port A read data, one-cycle registered latency
//   ram_dout_b_i   port B read data, one-cycle registered latency
//   vec_x_o        signed a_qq - a_pp, WORD_WIDTH+1 bits
//   vec_y_o        signed 2*a_pq, WORD_WIDTH+1 bits
//   vec_vld_o      one-cycle CORDIC launch strobe
//   pair_p_o       p of the issued pair
//   pair_q_o       q of the issued pair
//   pair_vld_o     high together with vec_vld_o
//   rot_done_i     pair-complete pulse from the rotation/writeback stage
//   sweep_cnt_o    number of completed sweeps
//   skip_o         (JACOBI_SKIP_ZERO_EN only) zero-a_pq skip pulse
// -----------------------------------------------------------------------------
module jacobi_pair_scheduler #(
    parameter int unsigned N              = 4,
    parameter int unsigned WORD_WIDTH     = 16,
    parameter int unsigned MEM_ADDR_WIDTH = 4,
    parameter int unsigned SWEEPS         = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          ram_en_o,
    output logic [MEM_ADDR_WIDTH-1:0]     ram_addr_a_o,
    output logic [MEM_ADDR_WIDTH-1:0]     ram_addr_b_o,
    input  logic [WORD_WIDTH-1:0]         ram_dout_a_i,
    input  logic [WORD_WIDTH-1:0]         ram_dout_b_i,
    output logic [WORD_WIDTH:0]           vec_x_o,
    output logic [WORD_WIDTH:0]           vec_y_o,
    output logic                          vec_vld_o,
    output logic [$clog2(N)-1:0]          pair_p_o,
    output logic [$clog2(N)-1:0]          pair_q_o,
    output logic                          pair_vld_o,
    input  logic                          rot_done_i,
    output logic [$clog2(SWEEPS+1)-1:0]   sweep_cnt_o
`ifdef JACOBI_SKIP_ZERO_EN
    ,
    output logic                          skip_o
`endif
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned CntW = $clog2(SWEEPS+1);

    typedef enum logic [2:0] {
        StIdle,
        StRdDiag,
        StRdOff,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         p_q, p_d;
    logic [IdxW-1:0]         q_q, q_d;
    logic [CntW-1:0]         sweep_q, sweep_d;
    logic [WORD_WIDTH-1:0]   app_q, app_d;
    logic [WORD_WIDTH-1:0]   aqq_q, aqq_d;
    logic [WORD_WIDTH:0]     vec_x_q, vec_x_d;
    logic [WORD_WIDTH:0]     vec_y_q, vec_y_d;
    logic                    vec_vld_q, vec_vld_d;
    logic [IdxW-1:0]         pair_p_q, pair_p_d;
    logic [IdxW-1:0]         pair_q_q, pair_q_d;
`ifdef JACOBI_SKIP_ZERO_EN
    logic                    skip_q, skip_d;
`endif

    // Pair advance, shared by rot_done_i in wait and by a skipped pair.
    logic [IdxW-1:0]         adv_p, adv_q;
    logic [CntW-1:0]         adv_sweep;
    logic                    adv_last;
    logic                    skip_pair;

    function automatic logic [MEM_ADDR_WIDTH-1:0] addr_of(input logic [IdxW-1:0] r,
                                                           input logic [IdxW-1:0] c);
        return MEM_ADDR_WIDTH'(32'(r) * N + 32'(c));
    endfunction

`ifdef JACOBI_SKIP_ZERO_EN
    // In issue, port A carries a_pq read during the off-diagonal cycle.
    assign skip_pair = (ram_dout_a_i == '0);
`else
    assign skip_pair = 1'b0;
`endif

    always_comb begin
        adv_p     = p_q;
        adv_q     = q_q;
        adv_sweep = sweep_q;
        adv_last  = 1'b0;
        if (q_q < IdxW'(N - 1)) begin
            adv_q = q_q + IdxW'(1);
        end else if (p_q < IdxW'(N - 2)) begin
            adv_p = p_q + IdxW'(1);
            adv_q = p_q + IdxW'(2);
        end else begin
            adv_sweep = sweep_q + CntW'(1);
            adv_p     = '0;
            adv_q     = IdxW'(1);
            adv_last  = (adv_sweep == CntW'(SWEEPS));
        end
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        q_d          = q_q;
        sweep_d      = sweep_q;
        app_d        = app_q;
        aqq_d        = aqq_q;
        vec_x_d      = vec_x_q;
        vec_y_d      = vec_y_q;
        vec_vld_d    = 1'b0;
        pair_p_d     = pair_p_q;
        pair_q_d     = pair_q_q;
`ifdef JACOBI_SKIP_ZERO_EN
        skip_d       = 1'b0;
`endif
        ram_en_o     = 1'b0;
        ram_addr_a_o = '0;
        ram_addr_b_o = '0;
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRdDiag;
                    p_d     = '0;
                    q_d     = IdxW'(1);
                    sweep_d = '0;
                end
            end
            StRdDiag: begin
                ram_en_o     = 1'b1;
                ram_addr_a_o = addr_of(p_q, p_q);
                ram_addr_b_o = addr_of(q_q, q_q);
                state_d      = StRdOff;
            end
            StRdOff: begin
                ram_en_o     = 1'b1;
                ram_addr_a_o = addr_of(p_q, q_q);
                ram_addr_b_o = addr_of(q_q, p_q);
                // Diagonal words requested in the previous cycle arrive now.
                app_d        = ram_dout_a_i;
                aqq_d        = ram_dout_b_i;
                state_d      = StIssue;
            end
            StIssue: begin
                if (skip_pair) begin
`ifdef JACOBI_SKIP_ZERO_EN
                    skip_d = 1'b1;
`endif
                    p_d     = adv_p;
                    q_d     = adv_q;
                    sweep_d = adv_sweep;
                    state_d = adv_last ? StDone : StRdDiag;
                end else begin
                    // One extra bit holds both the difference and the doubling exactly.
                    vec_x_d   = {aqq_q[WORD_WIDTH-1], aqq_q} - {app_q[WORD_WIDTH-1], app_q};
                    vec_y_d   = {ram_dout_a_i, 1'b0};
                    pair_p_d  = p_q;
                    pair_q_d  = q_q;
                    vec_vld_d = 1'b1;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (rot_done_i) begin
                    p_d     = adv_p;
                    q_d     = adv_q;
                    sweep_d = adv_sweep;
                    state_d = adv_last ? StDone : StRdDiag;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            p_q       <= '0;
            q_q       <= '0;
            sweep_q   <= '0;
            app_q     <= '0;
            aqq_q     <= '0;
            vec_x_q   <= '0;
            vec_y_q   <= '0;
            vec_vld_q <= 1'b0;
            pair_p_q  <= '0;
            pair_q_q  <= '0;
`ifdef JACOBI_SKIP_ZERO_EN
            skip_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            sweep_q   <= sweep_d;
            app_q     <= app_d;
            aqq_q     <= aqq_d;
            vec_x_q   <= vec_x_d;
            vec_y_q   <= vec_y_d;
            vec_vld_q <= vec_vld_d;
            pair_p_q  <= pair_p_d;
            pair_q_q  <= pair_q_d;
`ifdef JACOBI_SKIP_ZERO_EN
            skip_q    <= skip_d;
`endif
        end
    end

    assign vec_x_o     = vec_x_q;
    assign vec_y_o     = vec_y_q;
    assign vec_vld_o   = vec_vld_q;
    assign pair_vld_o  = vec_vld_q;
    assign pair_p_o    = pair_p_q;
    assign pair_q_o    = pair_q_q;
    assign sweep_cnt_o = sweep_q;
`ifdef JACOBI_SKIP_ZERO_EN
    assign skip_o      = skip_q;
`endif

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// Testbench for jacobi_pair_scheduler: BRAM model, randomized rot_done_i responder,
// reference scoreboard of expected reads/launches, and decoupled monitors.
module tb_jacobi_pair_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 4;
    localparam int SW = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start_i;
    logic                     busy_o, done_o, ram_en_o;
    logic [AW-1:0]            ram_addr_a_o, ram_addr_b_o;
    logic [W-1:0]             dout_a = '0, dout_b = '0;
    logic signed [W:0]        vec_x, vec_y;
    logic                     vec_vld_o, pair_vld_o;
    logic [$clog2(N)-1:0]     pair_p_o, pair_q_o;
    logic                     rot_done_i;
    logic [$clog2(SW+1)-1:0]  sweep_cnt;
    logic                     skip_sig;

    always #5 clk = ~clk;

    jacobi_pair_scheduler #(
        .N              (N),
        .WORD_WIDTH     (W),
        .MEM_ADDR_WIDTH (AW),
        .SWEEPS         (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ram_en_o     (ram_en_o),
        .ram_addr_a_o (ram_addr_a_o),
        .ram_addr_b_o (ram_addr_b_o),
        .ram_dout_a_i (dout_a),
        .ram_dout_b_i (dout_b),
        .vec_x_o      (vec_x),
        .vec_y_o      (vec_y),
        .vec_vld_o    (vec_vld_o),
        .pair_p_o     (pair_p_o),
        .pair_q_o     (pair_q_o),
        .pair_vld_o   (pair_vld_o),
        .rot_done_i   (rot_done_i),
        .sweep_cnt_o  (sweep_cnt)
`ifdef JACOBI_SKIP_ZERO_EN
        ,
        .skip_o       (skip_sig)
`endif
    );
`ifndef JACOBI_SKIP_ZERO_EN
    assign skip_sig = 1'b0;
`endif

    // Dual-port BRAM with one-cycle registered read.
    logic signed [W-1:0] mem [N*N];
    always @(posedge clk) begin
        if (ram_en_o) begin
            dout_a <= mem[ram_addr_a_o];
            dout_b <= mem[ram_addr_b_o];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int p; int q; int s; int x; int y; bit skip; } ev_t;
    typedef struct { int a; int b; } ad_t;
    ev_t exp_ev[$];
    ad_t exp_addr[$];

    int  n_chk = 0;
    int  n_pass = 0;
    int  trig = 0;
    int  done_seen = 0;
    bit  run_active = 0;
    bit  first_pending = 0;
    int  first_x = 0, first_y = 0;
    bit  seen02 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic signed [W-1:0] rand_word();
        logic signed [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 16'sh8000;
            1: v = 16'sh7FFF;
            2: v = '0;
            3: v = W'($urandom_range(0, 20)) - 16'sd10;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic rand_matrix();
        for (int r = 0; r < N; r++)
            for (int c = r; c < N; c++) begin
                mem[r*N+c] = rand_word();
                mem[c*N+r] = mem[r*N+c];
            end
    endtask

    // Reference: every pair of every sweep in cyclic-by-row order, plus its reads.
    task automatic push_run();
        ev_t e;
        ad_t a;
        for (int s = 0; s < SW; s++)
            for (int p = 0; p < N - 1; p++)
                for (int q = p + 1; q < N; q++) begin
                    a.a = p*N + p; a.b = q*N + q; exp_addr.push_back(a);
                    a.a = p*N + q; a.b = q*N + p; exp_addr.push_back(a);
                    e.p = p; e.q = q; e.s = s;
                    e.x = int'(mem[q*N+q]) - int'(mem[p*N+p]);
                    e.y = 2 * int'(mem[p*N+q]);
                    e.skip = 1'b0;
`ifdef JACOBI_SKIP_ZERO_EN
                    e.skip = (mem[p*N+q] == 0);
`endif
                    exp_ev.push_back(e);
                end
    endtask

    // Responder: rot_done_i 1..4 cycles after each launch, with random
    // stray pulses in the read/issue cycles that follow, which must be ignored.
    initial begin
        int cnt;
        int post;
        cnt = -1;
        post = 0;
        rot_done_i = 1'b0;
        forever begin
            @(negedge clk);
            rot_done_i = 1'b0;
            if (!rst) begin
                cnt = -1;
                post = 0;
            end else begin
                if (post > 0) begin
                    rot_done_i = ($urandom_range(0, 1) == 1);
                    post--;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        rot_done_i = 1'b1;
                        trig = cyc;
                        cnt = -1;
                        post = 3;
                    end
                end
                if (vec_vld_o) cnt = $urandom_range(1, 4);
            end
        end
    end

    // Address monitor.
    initial begin
        ad_t ad;
        forever begin
            @(negedge clk);
            if (rst && ram_en_o) begin
                if (exp_addr.size() == 0) check("addr_unexpected", 1, 0);
                else begin
                    ad = exp_addr.pop_front();
                    check("addr_a", int'(ram_addr_a_o), ad.a);
                    check("addr_b", int'(ram_addr_b_o), ad.b);
                end
            end
        end
    end

    // Launch/skip monitor.
    initial begin
        ev_t e;
        bit  have_last;
        int  last_x;
        have_last = 0;
        last_x = 0;
        forever begin
            @(negedge clk);
            if (!rst) have_last = 0;
            else if (vec_vld_o || skip_sig) begin
                if (exp_ev.size() == 0) check("issue_unexpected", 1, 0);
                else begin
                    e = exp_ev.pop_front();
                    check("issue_latency", cyc, trig + 4);
                    check("issue_sweep", int'(sweep_cnt), e.s);
                    if (vec_vld_o) begin
                        check("launch_kind", 0, int'(e.skip));
                        check("pair_vld", int'(pair_vld_o), 1);
                        check("pair_p", int'(pair_p_o), e.p);
                        check("pair_q", int'(pair_q_o), e.q);
                        check("vec_x", int'(vec_x), e.x);
                        check("vec_y", int'(vec_y), e.y);
                        if (first_pending) begin
                            first_x = int'(vec_x);
                            first_y = int'(vec_y);
                            first_pending = 0;
                        end
                        if (e.p == 0 && e.q == 2) seen02 = 1;
                        have_last = 1;
                        last_x = int'(vec_x);
                    end else begin
                        check("skip_kind", 1, int'(e.skip));
                        check("skip_no_vld", int'(vec_vld_o), 0);
                        trig = cyc - 1;
                    end
                end
            end else begin
                check("pair_vld_low", int'(pair_vld_o), 0);
                if (have_last) check("vec_x_hold", int'(vec_x), last_x);
            end
        end
    end

    // Done monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && done_o) begin
                check("done_expected", int'(run_active), 1);
                check("done_latency", cyc, trig + 1);
                check("done_events_left", exp_ev.size(), 0);
                check("done_addr_left", exp_addr.size(), 0);
                check("done_sweep", int'(sweep_cnt), SW);
                check("done_busy", int'(busy_o), 1);
                run_active = 0;
                done_seen++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        start_i = 1'b0;
        exp_ev.delete();
        exp_addr.delete();
        run_active = 0;
        first_pending = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_ram_en", int'(ram_en_o), 0);
        check("rst_addr_a", int'(ram_addr_a_o), 0);
        check("rst_addr_b", int'(ram_addr_b_o), 0);
        check("rst_vec_x", int'(vec_x), 0);
        check("rst_vec_y", int'(vec_y), 0);
        check("rst_vec_vld", int'(vec_vld_o), 0);
        check("rst_pair_p", int'(pair_p_o), 0);
        check("rst_pair_q", int'(pair_q_o), 0);
        check("rst_pair_vld", int'(pair_vld_o), 0);
        check("rst_sweep", int'(sweep_cnt), 0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic launch_run();
        push_run();
        run_active = 1;
        first_pending = 1;
        start_i = 1'b1;
        trig = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run_matrix(input bit busy_starts, input bit chk_first,
                              input int fx, input int fy);
        int ds0;
        ds0 = done_seen;
        launch_run();
        for (int i = 0; i < 3000 && done_seen == ds0; i++) begin
            @(negedge clk);
            // Starts while busy, including the done cycle, must be ignored.
            start_i = busy_starts && busy_o && (done_o || $urandom_range(0, 5) == 0);
        end
        start_i = 1'b0;
        if (done_seen == ds0) begin
            check("run_timeout", 0, 1);
            do_reset();
        end else begin
            @(negedge clk);
            check("end_busy", int'(busy_o), 0);
            check("end_done_pulse", int'(done_o), 0);
            check("end_sweep_hold", int'(sweep_cnt), SW);
            if (chk_first) begin
                check("first_vec_x", first_x, fx);
                check("first_vec_y", first_y, fy);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < N*N; i++) mem[i] = '0;
        @(negedge clk);
        do_reset();

        rand_matrix();
        mem[0] = 16'sd10;
        mem[5] = 16'sd3;
        mem[1] = -16'sd4;
        mem[4] = -16'sd4;
        run_matrix(1'b1, 1'b1, -7, -8);

        rand_matrix();
        mem[0] = 16'sh8000;
        mem[5] = 16'sh7FFF;
        mem[1] = 16'sh8000;
        mem[4] = 16'sh8000;
        run_matrix(1'b0, 1'b1, 65535, -65536);

        for (int r = 0; r < 4; r++) begin
            rand_matrix();
            run_matrix(1'b1, 1'b0, 0, 0);
        end

        // Reset while waiting on pair (0,2), then a fresh run from (0,1).
        rand_matrix();
        mem[2] = 16'sd7;
        mem[8] = 16'sd7;
        seen02 = 0;
        launch_run();
        for (int i = 0; i < 500 && !seen02; i++) @(negedge clk);
        if (!seen02) check("reset_wait_timeout", 0, 1);
        do_reset();
        rand_matrix();
        run_matrix(1'b1, 1'b0, 0, 0);

`ifdef JACOBI_SKIP_ZERO_EN
        rand_matrix();
        mem[1] = 16'sd5;
        mem[4] = 16'sd5;
        mem[2] = '0;
        mem[8] = '0;
        run_matrix(1'b0, 1'b0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jacobi_pair_scheduler.md
Name: jacobi_pair_scheduler

Overview:
- Sequences one cyclic-by-row Jacobi run over an N x N symmetric matrix held in the shared dual-port BRAM, stored row-major.
- For each (p,q) pair it:
  - reads a_pp, a_qq and a_pq from the BRAM;
  - launches the vectoring CORDIC with x = a_qq - a_pp and y = 2*a_pq;
  - waits for the rotation/writeback stage to report the pair complete.
- It runs SWEEPS full sweeps, then signals done.
- It is a sub-controller instantiated by the Jacobi main controller.

Parameters:
- N, 4, matrix dimension (>= 3).
- WORD_WIDTH, 16, BRAM word width; entries are signed two's complement.
- MEM_ADDR_WIDTH, 4, BRAM address width; must satisfy 2**MEM_ADDR_WIDTH >= N*N.
- SWEEPS, 6, number of full sweeps per run (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start_i  in  1  run request pulse; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of run.
- ram_en_o  out  1  BRAM enable, both ports.
- ram_addr_a_o  out  MEM_ADDR_WIDTH  port A read address.
- ram_addr_b_o  out  MEM_ADDR_WIDTH  port B read address.
- ram_dout_a_i  in  WORD_WIDTH  port A read data; 1-cycle registered latency.
- ram_dout_b_i  in  WORD_WIDTH  port B read data; 1-cycle registered latency.
- vec_x_o  out  WORD_WIDTH+1  signed a_qq - a_pp.
- vec_y_o  out  WORD_WIDTH+1  signed 2*a_pq.
- vec_vld_o  out  1  one-cycle CORDIC launch strobe.
- pair_p_o  out  $clog2(N)  current p.
- pair_q_o  out  $clog2(N)  current q.
- pair_vld_o  out  1  high together with vec_vld_o.
- rot_done_i  in  1  pair-complete pulse from the rotation/writeback stage.
- sweep_cnt_o  out  $clog2(SWEEPS+1)  number of completed sweeps.

Behaviour:
- Reset: rst=0 at a clock edge puts the FSM in IDLE and clears every output and register to 0, including p, q and sweep. This applies from any state, mid-run included; no done_o is produced.
- RAM outputs are combinational from the state and the p/q registers. Writes are never issued by this block.
- IDLE -> RD_DIAG on start_i. Load p=0, q=1, sweep=0.
- RD_DIAG:
  - ram_en_o=1, addr_a = p*N+p, addr_b = q*N+q.
  - Next state: RD_OFF.
- RD_OFF:
  - ram_en_o=1, addr_a = p*N+q, addr_b = q*N+p.
  - Capture app <= dout_a and aqq <= dout_b.
  - Next state: ISSUE.
- ISSUE:
  - Register vec_x_o <= sext(aqq) - sext(app).
  - Register vec_y_o <= sext(dout_a) << 1.
  - No saturation needed; both results fit in WORD_WIDTH+1 bits.
  - Set vec_vld_o and pair_vld_o for the next cycle only.
  - Next state: WAIT.
- Latency: start_i sampled at edge 0 gives vec_vld_o high in cycle 4. Between pairs, rot_done_i to the next vec_vld_o is also 4 cycles.
- WAIT: hold until rot_done_i=1, then advance the pair:
  - if q < N-1: q++;
  - else if p < N-2: p++, q = p+2 (using the new p);
  - else end of sweep: sweep_cnt_o++. If the sweep count now equals SWEEPS, go to DONE. Otherwise set p=0, q=1 and continue.
  - When not going to DONE, next state is RD_DIAG.
- A sweep contains N(N-1)/2 pairs.
- DONE: done_o=1 for one cycle, then IDLE. sweep_cnt_o holds its value until the next start_i.
- rot_done_i outside WAIT is ignored, including in the same cycle as vec_vld_o when it occurs outside WAIT.
- start_i while busy is ignored. start_i in the DONE cycle is ignored.
- The vec/pair outputs hold their last value; only the strobes drop to 0.

Optional Feature:
- Macro: JACOBI_SKIP_ZERO_EN.
- Defined:
  - In ISSUE, if dout_a (a_pq) == 0, no vec_vld_o or pair_vld_o is asserted.
  - The pair is advanced directly, exactly as on rot_done_i, and the FSM goes to RD_DIAG or DONE.
  - Port skip_o (out, 1) pulses for one cycle in that case.
- Undefined: every pair is issued, and the skip_o port does not exist.

Test Plan:
- N=4, SWEEPS=1, rot_done_i 2 cycles after each vec_vld_o -> pairs issued in order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); done_o once after the 6th rot_done_i; sweep_cnt_o=1; busy_o then 0.
- Pair (1,3) -> RD_DIAG addr_a=5, addr_b=15; RD_OFF addr_a=7, addr_b=13.
- a_pp=10, a_qq=3, a_pq=-4 (WORD_WIDTH=16) -> vec_x_o=-7, vec_y_o=-8, vec_vld_o exactly 4 cycles after start_i.
- a_pp=-32768, a_qq=32767 -> vec_x_o=65535 (17-bit, no overflow); a_pq=-32768 -> vec_y_o=-65536.
- rst=0 during WAIT of pair (0,2), then start_i -> all outputs 0 after reset; new run begins at (0,1) with sweep_cnt_o=0. Also: start_i pulses while busy -> no effect.
- JACOBI_SKIP_ZERO_EN defined, a_pq=0 for pair (0,2) -> skip_o pulse, no vec_vld_o for (0,2), next RD_DIAG addresses 0 and 15 for pair (0,3).
